// File: rtl/apb_pkg.sv
// Shared APB definitions for the 4-bit-address / 8-bit-data peripheral bus:
// bus widths, the completer state encoding and the address-decode helper.
package apb_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } slv_state_e;

    // True when the address falls inside a bank of num_regs registers.
    function automatic logic addr_mapped(input logic [ADDR_W-1:0] addr,
                                         input int unsigned        num_regs);
        return 32'(addr) < num_regs;
    endfunction

endpackage

// File: rtl/apb_regfile.sv
// NUM_REGS x DATA_W register file: one synchronous write port, one
// combinational read port returning 0 for addresses outside the bank.
module apb_regfile
    import apb_pkg::*;
#(
    parameter int NUM_REGS = 12
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // NOTE: the storage is flops, not a RAM macro, so every entry is reset;
    // software relies on reading 0 from any register after reset.
    always_ff @(posedge pclk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (prst) begin
                mem[i] <= '0;
            end else if (we && 32'(waddr) == i) begin
                mem[i] <= wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (addr_mapped(raddr, NUM_REGS)) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/apb_slave_regs.sv
// APB completer for one register bank: SETUP/ACCESS decode, registered
// pready/pslverr/prdata. Wait states are built only with APB_SLV_WAIT_EN.
module apb_slave_regs
    import apb_pkg::*;
#(
    parameter int NUM_REGS    = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    slv_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] prdata_d;
    logic              pready_d, pslverr_d;

    logic              start, respond, we;
    logic [ADDR_W-1:0] resp_addr;
    logic              resp_write, resp_mapped;
    logic [DATA_W-1:0] rd_data;

`ifdef APB_SLV_WAIT_EN
    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);
    logic [2:0] cnt_q, cnt_d;
`else
    logic unused_wait_cfg;
    assign unused_wait_cfg = (WAIT_CYCLES != 0);
`endif

    apb_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
        .pclk  (pclk),
        .prst  (prst),
        .we    (we),
        .waddr (addr_q),
        .wdata (wdata_q),
        .raddr (resp_addr),
        .rdata (rd_data)
    );

    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        start      = 1'b0;
        respond    = 1'b0;
        we         = 1'b0;
        resp_addr  = addr_q;
        resp_write = write_q;
        prdata_d   = '0;
        pready_d   = 1'b0;
        pslverr_d  = 1'b0;
`ifdef APB_SLV_WAIT_EN
        cnt_d      = cnt_q;
`endif

        case (state_q)
            IDLE: start = psel && !penable;
`ifdef APB_SLV_WAIT_EN
            WAIT: begin
                if (!(psel && penable)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = DONE;
                        respond = 1'b1;
                    end
                end
            end
`endif
            DONE: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (penable) begin
                    we      = write_q && addr_mapped(addr_q, NUM_REGS);
                    state_d = IDLE;
                end else begin
                    start = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A zero-wait response is built from the bus, not the latches,
        // because both are captured on the same edge.
        if (start) begin
            addr_d     = paddr;
            write_d    = pwrite;
            wdata_d    = pwdata;
            resp_addr  = paddr;
            resp_write = pwrite;
`ifdef APB_SLV_WAIT_EN
            cnt_d = WAIT_LOAD;
            if (WAIT_LOAD == 3'd0) begin
                state_d = DONE;
                respond = 1'b1;
            end else begin
                state_d = WAIT;
            end
`else
            state_d = DONE;
            respond = 1'b1;
`endif
        end

        resp_mapped = addr_mapped(resp_addr, NUM_REGS);
        if (respond) begin
            pready_d  = 1'b1;
            pslverr_d = !resp_mapped;
            prdata_d  = (!resp_write && resp_mapped) ? rd_data : '0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            prdata  <= prdata_d;
            pready  <= pready_d;
            pslverr <= pslverr_d;
        end
    end

`ifdef APB_SLV_WAIT_EN
    always_ff @(posedge pclk) begin
        if (prst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_apb_slave_regs.sv
// Self-checking bench for apb_slave_regs: transfer-level model of the bank
// and the expected response timing, compared against the DUT every cycle.
module tb_apb_slave_regs;
    import apb_pkg::*;

    localparam int NREGS   = 12;
    localparam int TB_WAIT = 2;
`ifdef APB_SLV_WAIT_EN
    localparam int EXP_WAIT = TB_WAIT;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic        pclk = 1'b0;
    logic        prst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  paddr;
    logic [7:0]  pwdata;
    logic [7:0]  prdata;
    logic        pready;
    logic        pslverr;

    logic [7:0]  mem [16];
    logic        exp_pready;
    logic        exp_pslverr;
    logic [7:0]  exp_prdata;
    bit          check_en = 1'b0;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          last_lat;
    logic [7:0]  last_rdata;
    logic        last_err;

    apb_slave_regs #(.NUM_REGS(NREGS), .WAIT_CYCLES(TB_WAIT)) dut (
        .pclk    (pclk),
        .prst    (prst),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge pclk) begin
        if (check_en) begin
            check("pready",  32'(pready),  32'(exp_pready));
            check("pslverr", 32'(pslverr), 32'(exp_pslverr));
            check("prdata",  32'(prdata),  32'(exp_prdata));
        end
    end

    task automatic clear_exp();
        exp_pready  = 1'b0;
        exp_pslverr = 1'b0;
        exp_prdata  = 8'h00;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after completion
    // with the bus idle, so a following call starts back-to-back.
    task automatic xfer(input bit wr, input logic [3:0] a, input logic [7:0] d);
        bit mapped;
        mapped   = 32'(a) < NREGS;
        psel     = 1'b1;
        penable  = 1'b0;
        pwrite   = wr;
        paddr    = a;
        pwdata   = d;
        clear_exp();
        last_lat = 99;
        for (int k = 0; k <= EXP_WAIT; k++) begin
            @(posedge pclk);
            #1;
            penable     = 1'b1;
            paddr       = ~a;
            pwdata      = ~d;
            exp_pready  = (k == EXP_WAIT);
            exp_pslverr = exp_pready && !mapped;
            exp_prdata  = (exp_pready && !wr && mapped) ? mem[a] : 8'h00;
            @(negedge pclk);
            if (pready && last_lat == 99) last_lat = k;
            if (k == EXP_WAIT) begin
                last_rdata = prdata;
                last_err   = pslverr;
            end
        end
        @(posedge pclk);
        #1;
        if (wr && mapped) mem[a] = d;
        psel    = 1'b0;
        penable = 1'b0;
        clear_exp();
    endtask

    task automatic abort_write(input logic [3:0] a, input logic [7:0] d);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = a;
        pwdata  = d;
        clear_exp();
        @(posedge pclk);
        #1;
        psel       = 1'b0;
        exp_pready = (EXP_WAIT == 0);
        @(posedge pclk);
        #1;
        clear_exp();
    endtask

    task automatic reset_during_write(input logic [3:0] a, input logic [7:0] d);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = a;
        pwdata  = d;
        clear_exp();
        @(posedge pclk);
        #1;
        penable    = 1'b1;
        prst       = 1'b1;
        exp_pready = (EXP_WAIT == 0);
        @(posedge pclk);
        #1;
        prst    = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        clear_exp();
    endtask

    initial begin
        prst    = 1'b1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 4'h0;
        pwdata  = 8'h00;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        clear_exp();

        repeat (2) @(posedge pclk);
        #1;
        check_en = 1'b1;
        @(negedge pclk);
        check("reset prdata",  32'(prdata),  32'h00);
        check("reset pready",  32'(pready),  32'h0);
        check("reset pslverr", 32'(pslverr), 32'h0);
        @(posedge pclk);
        #1;
        prst = 1'b0;

        // Basic write then read, with the first pready cycle pinned.
        xfer(1'b1, 4'd3, 8'hA5);
        check("write latency", 32'(last_lat), 32'(EXP_WAIT));
        xfer(1'b0, 4'd3, 8'h00);
        check("read latency", 32'(last_lat), 32'(EXP_WAIT));
        check("read a3 data", 32'(last_rdata), 32'hA5);
        check("read a3 err",  32'(last_err),   32'h0);

        xfer(1'b1, 4'd0, 8'h3C);
        xfer(1'b0, 4'd0, 8'h00);
        check("read a0 data", 32'(last_rdata), 32'h3C);

        // Unmapped address: error response, write dropped.
        @(posedge pclk);
        #1;
        xfer(1'b1, 4'd14, 8'hFF);
        check("unmapped write err", 32'(last_err), 32'h1);
        xfer(1'b0, 4'd14, 8'h00);
        check("unmapped read err",  32'(last_err),   32'h1);
        check("unmapped read data", 32'(last_rdata), 32'h00);
        xfer(1'b0, 4'd15, 8'h00);

        // Back-to-back writes and reads, no idle cycle.
        xfer(1'b1, 4'd1, 8'h11);
        xfer(1'b1, 4'd2, 8'h22);
        xfer(1'b0, 4'd1, 8'h00);
        check("b2b read a1", 32'(last_rdata), 32'h11);
        xfer(1'b0, 4'd2, 8'h00);
        check("b2b read a2", 32'(last_rdata), 32'h22);
        xfer(1'b1, 4'd11, 8'hC3);
        for (int i = 0; i < NREGS; i++) xfer(1'b0, 4'(i), 8'h00);

        // Abort: psel dropped in the first access cycle.
        xfer(1'b1, 4'd5, 8'h5A);
        abort_write(4'd5, 8'h77);
        xfer(1'b0, 4'd5, 8'h00);
        check("abort keeps a5", 32'(last_rdata), 32'h5A);

        // Reset during the access phase of a write.
        reset_during_write(4'd4, 8'h55);
        @(negedge pclk);
        check("post-reset pready", 32'(pready), 32'h0);
        check("post-reset prdata", 32'(prdata), 32'h00);
        @(posedge pclk);
        #1;
        xfer(1'b0, 4'd4, 8'h00);
        check("a4 after reset", 32'(last_rdata), 32'h00);
        xfer(1'b0, 4'd3, 8'h00);
        check("a3 after reset", 32'(last_rdata), 32'h00);

        repeat (3) @(posedge pclk);
        #1;
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
